// File: rtl/half_adder_pkg.sv
// half_adder_pkg -- shared constants and helpers for the half_adder block.
//   CNT_W_DEFAULT : default event-counter width
//   CNT_W_MIN/MAX : legal counter width range
//   sat_max()     : all-ones saturation value for a given counter width
package half_adder_pkg;

    localparam int unsigned CNT_W_DEFAULT = 16;
    localparam int unsigned CNT_W_MIN     = 4;
    localparam int unsigned CNT_W_MAX     = 32;

    // Largest value representable in w bits, returned in the widest legal width.
    function automatic logic [CNT_W_MAX-1:0] sat_max(input int unsigned w);
        logic [CNT_W_MAX-1:0] ones;
        ones = '1;
        if (w >= CNT_W_MAX) begin
            return ones;
        end
        return ones >> (CNT_W_MAX - w);
    endfunction

endpackage

// File: rtl/half_adder_core.sv
// half_adder_core -- purely combinational one-bit half adder.
//   a, b  : addend bits
//   sum   : a XOR b
//   carry : a AND b
module half_adder_core (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/half_adder.sv
// half_adder -- half adder with combinational outputs, a registered result
// path qualified by in_valid, and optional saturating event counters.
//
// Optional feature macro: HALF_ADDER_STATS_EN (adds op_cnt / carry_cnt).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (registers only)
//   A, B       addend bits
//   in_valid   qualifies A/B for the registered path and counters
//   Sum, Carry combinational A^B, A&B
//   sum_q      registered Sum of the last accepted pair
//   carry_q    registered Carry of the last accepted pair
//   out_valid  high for the single cycle after each accepted pair
//   carry_cnt  accepted pairs with Carry=1, saturating (STATS_EN only)
//   op_cnt     accepted pairs, saturating (STATS_EN only)
module half_adder
    import half_adder_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             A,
    input  logic             B,
    input  logic             in_valid,
    output logic             Sum,
    output logic             Carry,
    output logic             sum_q,
    output logic             carry_q,
    output logic             out_valid
`ifdef HALF_ADDER_STATS_EN
    ,
    output logic [CNT_W-1:0] carry_cnt,
    output logic [CNT_W-1:0] op_cnt
`endif
);

    if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
        $error("half_adder: CNT_W out of legal range");
    end

    logic core_sum;
    logic core_carry;

    half_adder_core u_core (
        .a     (A),
        .b     (B),
        .sum   (core_sum),
        .carry (core_carry)
    );

    assign Sum   = core_sum;
    assign Carry = core_carry;

    logic sum_d;
    logic carry_d;
    logic out_valid_q;
    logic out_valid_d;

    // The select is in_valid alone, so unknown A/B while idle never reach a flop.
    always_comb begin
        sum_d       = sum_q;
        carry_d     = carry_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            sum_d       = core_sum;
            carry_d     = core_carry;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q       <= 1'b0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;

`ifdef HALF_ADDER_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

    logic [CNT_W-1:0] op_cnt_q;
    logic [CNT_W-1:0] op_cnt_d;
    logic [CNT_W-1:0] carry_cnt_q;
    logic [CNT_W-1:0] carry_cnt_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        op_cnt_d    = op_cnt_q;
        carry_cnt_d = carry_cnt_q;
        if (in_valid) begin
            if (op_cnt_q != CNT_MAX) begin
                op_cnt_d = op_cnt_q + 1'b1;
            end
            if (core_carry && (carry_cnt_q != CNT_MAX)) begin
                carry_cnt_d = carry_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_cnt_q    <= '0;
            carry_cnt_q <= '0;
        end else begin
            op_cnt_q    <= op_cnt_d;
            carry_cnt_q <= carry_cnt_d;
        end
    end

    assign op_cnt    = op_cnt_q;
    assign carry_cnt = carry_cnt_q;
`endif

endmodule

// File: tb/tb_half_adder.sv
// tb_half_adder -- self-checking bench for half_adder (CNT_W=4).
// Works with or without HALF_ADDER_STATS_EN defined.
module tb_half_adder;

    localparam int unsigned CNT_W = 4;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic A;
    logic B;
    logic in_valid;
    logic Sum;
    logic Carry;
    logic sum_q;
    logic carry_q;
    logic out_valid;
`ifdef HALF_ADDER_STATS_EN
    logic [CNT_W-1:0] carry_cnt;
    logic [CNT_W-1:0] op_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    half_adder #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .in_valid  (in_valid),
        .Sum       (Sum),
        .Carry     (Carry),
        .sum_q     (sum_q),
        .carry_q   (carry_q),
        .out_valid (out_valid)
`ifdef HALF_ADDER_STATS_EN
        ,
        .carry_cnt (carry_cnt),
        .op_cnt    (op_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the result of an accepted pair is just the 2-bit
    // arithmetic sum A+B split into its low and high bits.
    bit model_known = 1'b0;
    int m_sum, m_carry, m_ov, m_op, m_cc;

    always @(posedge clk) begin
        if (rst_n === 1'b0) begin
            m_sum = 0; m_carry = 0; m_ov = 0; m_op = 0; m_cc = 0;
            model_known = 1'b1;
        end else if (in_valid === 1'b1) begin
            int s;
            s       = int'(A) + int'(B);
            m_sum   = s % 2;
            m_carry = s / 2;
            m_ov    = 1;
            if (m_op < CMAX) m_op++;
            if (m_carry == 1 && m_cc < CMAX) m_cc++;
        end else begin
            m_ov = 0;
        end
    end

    // Compare on the falling edge, clear of the active edge.
    always @(negedge clk) begin
        if (!$isunknown({A, B})) begin
            chk("comb_sum",   32'(Sum),   32'((int'(A) + int'(B)) % 2));
            chk("comb_carry", 32'(Carry), 32'((int'(A) + int'(B)) / 2));
        end
        if (model_known) begin
            chk("sum_q",     32'(sum_q),     32'(m_sum));
            chk("carry_q",   32'(carry_q),   32'(m_carry));
            chk("out_valid", 32'(out_valid), 32'(m_ov));
`ifdef HALF_ADDER_STATS_EN
            chk("op_cnt",    32'(op_cnt),    32'(m_op));
            chk("carry_cnt", 32'(carry_cnt), 32'(m_cc));
`endif
        end
    end

    // Drive inputs (called at edge+1), then advance to 1 unit after the next edge.
    task automatic step(input logic r, input logic a, input logic b, input logic v);
        rst_n = r; A = a; B = b; in_valid = v;
        @(posedge clk);
        #1;
    endtask

    logic [1:0] tt_in   [4];
    logic [1:0] tt_out  [4];
    logic [1:0] st_in   [3];
    logic [1:0] st_out  [3];

    initial begin
        tt_in  = '{2'b00, 2'b01, 2'b10, 2'b11};
        tt_out = '{2'b00, 2'b10, 2'b10, 2'b01};   // {Sum, Carry}
        st_in  = '{2'b01, 2'b11, 2'b00};
        st_out = '{2'b10, 2'b01, 2'b00};

        rst_n = 1'b0; A = 1'b0; B = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset state
        chk("rst_sum_q",     32'(sum_q),     32'd0);
        chk("rst_carry_q",   32'(carry_q),   32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);

        // Truth table, each held 10 time units, while held in reset
        for (int i = 0; i < 4; i++) begin
            A = tt_in[i][1]; B = tt_in[i][0];
            #5;
            chk("tt_sum",   32'(Sum),   32'(tt_out[i][1]));
            chk("tt_carry", 32'(Carry), 32'(tt_out[i][0]));
            #5;
        end

        // Registered path
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("reg_sum_q",   32'(sum_q),     32'd0);
        chk("reg_carry_q", 32'(carry_q),   32'd1);
        chk("reg_ov",      32'(out_valid), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("reg_ov_drop", 32'(out_valid), 32'd0);
        chk("reg_hold_c",  32'(carry_q),   32'd1);

        // Streaming three back-to-back pairs
        for (int i = 0; i < 3; i++) begin
            step(1'b1, st_in[i][1], st_in[i][0], 1'b1);
            chk("stream_sum",   32'(sum_q),     32'(st_out[i][1]));
            chk("stream_carry", 32'(carry_q),   32'(st_out[i][0]));
            chk("stream_ov",    32'(out_valid), 32'd1);
        end
        step(1'b1, 1'b1, 1'b1, 1'b1);

        // Reset collides with a valid 11 pair
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("coll_sum_q",   32'(sum_q),     32'd0);
        chk("coll_carry_q", 32'(carry_q),   32'd0);
        chk("coll_ov",      32'(out_valid), 32'd0);
        chk("coll_comb_c",  32'(Carry),     32'd1);
`ifdef HALF_ADDER_STATS_EN
        chk("coll_op_cnt",    32'(op_cnt),    32'd0);
        chk("coll_carry_cnt", 32'(carry_cnt), 32'd0);

        // Saturation: 20 carrying pairs into 4-bit counters
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("sat_op_cnt",    32'(op_cnt),    32'd15);
        chk("sat_carry_cnt", 32'(carry_cnt), 32'd15);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("sat_op_hold",   32'(op_cnt),    32'd15);
`endif

        // Randomized traffic, occasional reset, unknowns on idle cycles
        for (int i = 0; i < 400; i++) begin
            logic r, a, b, v;
            r = ($urandom_range(0, 19) != 0);
            v = $urandom_range(0, 2) != 0;
            a = 1'($urandom);
            b = 1'($urandom);
            if (!v && ($urandom_range(0, 3) == 0)) a = 1'bx;
            step(r, a, b, v);
        end

        step(1'b1, 1'b0, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
